mips_dbus_responder: RTL and testbench

Memory-mapped responder for the single-cycle MIPS data port. It answers the processor's `memwrite` / `memaddr` / `memwritedata` / `memreaddata` interface with a word RAM and a programmable timer peripheral. Reads are combinational so a load completes in the same cycle it issues. Writes and all timer state update on the rising clock edge.

---
 rtl/dbus_pkg.sv | 16 +
 rtl/dbus_timer.sv | 110 +++++++++++
 rtl/mips_dbus_responder.sv | 55 +++++
 tb/tb_mips_dbus_responder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_pkg.sv
// rtl/dbus_pkg.sv - shared timer register map, CTRL bit positions and default timer base
package dbus_pkg;

   localparam logic [4:0] TMR_CTRL     = 5'h00;
   localparam logic [4:0] TMR_PRESCALE = 5'h04;
   localparam logic [4:0] TMR_COUNT    = 5'h08;
   localparam logic [4:0] TMR_COMPARE  = 5'h0C;
   localparam logic [4:0] TMR_STATUS   = 5'h10;

   localparam int CTRL_EN    = 0;
   localparam int CTRL_AR    = 1;
   localparam int CTRL_IRQEN = 2;

   localparam logic [31:0] TIMER_BASE_DFLT = 32'hFFFF_0000;

endpackage

// File: rtl/dbus_timer.sv
// rtl/dbus_timer.sv - timer registers, prescaler, counter and match logic; irq_o only with TIMER_IRQ_EN
module dbus_timer
   import dbus_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        we_i,
   input  logic [4:0]  off_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o
`ifdef TIMER_IRQ_EN
   ,
   output logic        irq_o
`endif
);

`ifdef TIMER_IRQ_EN
   localparam logic [2:0] CTRL_MASK = 3'b111;
`else
   localparam logic [2:0] CTRL_MASK = 3'b011;
`endif

   logic [2:0]  ctrl_q, ctrl_d;
   logic [15:0] ps_q, ps_d;
   logic [15:0] pcnt_q, pcnt_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] cmp_q, cmp_d;
   logic        match_q, match_d;
   logic        tick, hit;

   always_comb begin
      ctrl_d  = ctrl_q;
      ps_d    = ps_q;
      pcnt_d  = pcnt_q;
      cnt_d   = cnt_q;
      cmp_d   = cmp_q;
      match_d = match_q;
      tick    = 1'b0;
      hit     = 1'b0;
      if (ctrl_q[CTRL_EN]) begin
         if (pcnt_q == ps_q) begin
            pcnt_d = '0;
            tick   = 1'b1;
         end else begin
            pcnt_d = pcnt_q + 16'd1;
         end
      end
      if (tick) begin
         hit   = (cnt_q == cmp_q);
         cnt_d = (hit && ctrl_q[CTRL_AR]) ? 32'd0 : cnt_q + 32'd1;
      end
      // CPU writes land after the tick update so they override it
      if (we_i) begin
         case (off_i)
            TMR_CTRL:     ctrl_d = wdata_i[2:0] & CTRL_MASK;
            TMR_PRESCALE: begin
               ps_d   = wdata_i[15:0];
               pcnt_d = '0;
            end
            TMR_COUNT:    cnt_d = wdata_i;
            TMR_COMPARE:  cmp_d = wdata_i;
            TMR_STATUS:   if (wdata_i[0]) match_d = 1'b0;
            default:      ;
         endcase
      end
      if (hit) match_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q  <= '0;
         ps_q    <= '0;
         pcnt_q  <= '0;
         cnt_q   <= '0;
         cmp_q   <= '0;
         match_q <= 1'b0;
      end else begin
         ctrl_q  <= ctrl_d;
         ps_q    <= ps_d;
         pcnt_q  <= pcnt_d;
         cnt_q   <= cnt_d;
         cmp_q   <= cmp_d;
         match_q <= match_d;
      end
   end

`ifdef TIMER_IRQ_EN
   logic irq_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) irq_q <= 1'b0;
      else     irq_q <= match_d & ctrl_d[CTRL_IRQEN];
   end

   assign irq_o = irq_q;
`endif

   always_comb begin
      rdata_o = '0;
      case (off_i)
         TMR_CTRL:     rdata_o = {29'd0, ctrl_q};
         TMR_PRESCALE: rdata_o = {16'd0, ps_q};
         TMR_COUNT:    rdata_o = cnt_q;
         TMR_COMPARE:  rdata_o = cmp_q;
         TMR_STATUS:   rdata_o = {31'd0, match_q};
         default:      rdata_o = '0;
      endcase
   end

endmodule

// File: rtl/mips_dbus_responder.sv
// rtl/mips_dbus_responder.sv - MIPS data-port responder: word RAM, timer and decode; irq only with TIMER_IRQ_EN
module mips_dbus_responder
   import dbus_pkg::*;
#(
   parameter int          RAM_WORDS  = 64,
   parameter logic [31:0] TIMER_BASE = TIMER_BASE_DFLT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [31:0] memaddr,
   input  logic [31:0] memwritedata,
   output logic [31:0] memreaddata
`ifdef TIMER_IRQ_EN
   ,
   output logic        irq
`endif
);

   localparam int AW = $clog2(RAM_WORDS);

   logic [31:0]   ram_q [RAM_WORDS];
   logic          ram_sel, tmr_sel;
   logic [AW-1:0] ram_idx;
   logic [31:0]   tmr_rdata;

   assign ram_sel = (memaddr < 32'(4 * RAM_WORDS));
   assign tmr_sel = (memaddr[31:5] == TIMER_BASE[31:5]);
   assign ram_idx = memaddr[AW+1:2];

   // RAM contents are deliberately left out of reset
   always_ff @(posedge clk) begin
      if (memwrite && ram_sel) ram_q[ram_idx] <= memwritedata;
   end

   dbus_timer u_timer (
      .clk     (clk),
      .rst     (reset),
      .we_i    (memwrite & tmr_sel),
      .off_i   ({memaddr[4:2], 2'b00}),
      .wdata_i (memwritedata),
      .rdata_o (tmr_rdata)
`ifdef TIMER_IRQ_EN
      ,
      .irq_o   (irq)
`endif
   );

   always_comb begin
      memreaddata = '0;
      if (ram_sel)      memreaddata = ram_q[ram_idx];
      else if (tmr_sel) memreaddata = tmr_rdata;
   end

endmodule

// File: tb/tb_mips_dbus_responder.sv
// tb/tb_mips_dbus_responder.sv - scoreboard bench with reference model; irq checked when TIMER_IRQ_EN is defined
module tb_mips_dbus_responder;

   localparam logic [31:0] TB = 32'hFFFF_0000;
`ifdef TIMER_IRQ_EN
   localparam logic [31:0] M_CTRL_MASK = 32'h7;
`else
   localparam logic [31:0] M_CTRL_MASK = 32'h3;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        memwrite = 1'b0;
   logic [31:0] memaddr = '0;
   logic [31:0] memwritedata = '0;
   logic [31:0] memreaddata;
`ifdef TIMER_IRQ_EN
   logic        irq;
`endif

   always #5 clk = ~clk;

   mips_dbus_responder dut (
      .clk          (clk),
      .reset        (reset),
      .memwrite     (memwrite),
      .memaddr      (memaddr),
      .memwritedata (memwritedata),
      .memreaddata  (memreaddata)
`ifdef TIMER_IRQ_EN
      ,
      .irq          (irq)
`endif
   );

   logic [31:0] exp_q[$];
   string       name_q[$];
   logic        chk_en = 1'b0;
   int          n_chk = 0;
   int          n_fail = 0;

   // reference model state
   logic [31:0] m_ram [64];
   logic [31:0] m_ctrl, m_cnt, m_cmp;
   logic [15:0] m_ps, m_pcnt;
   logic        m_match, m_irq;

   task automatic m_reset();
      m_ctrl = 0; m_ps = 0; m_pcnt = 0; m_cnt = 0; m_cmp = 0;
      m_match = 0; m_irq = 0;
   endtask

   function automatic logic [31:0] m_read(input logic [31:0] a);
      if (a < 32'd256) return m_ram[a[7:2]];
      if ((a & ~32'h1F) == TB) begin
         case (a[4:2])
            3'd0: return m_ctrl;
            3'd1: return {16'd0, m_ps};
            3'd2: return m_cnt;
            3'd3: return m_cmp;
            3'd4: return {31'd0, m_match};
            default: return 32'd0;
         endcase
      end
      return 32'd0;
   endfunction

   task automatic m_step(input logic we, input logic [31:0] a, input logic [31:0] d);
      logic        tick, hit, match_n;
      logic [15:0] pcnt_n;
      logic [31:0] cnt_n;
      tick = 0; hit = 0; pcnt_n = m_pcnt; cnt_n = m_cnt; match_n = m_match;
      if (m_ctrl[0]) begin
         if (m_pcnt == m_ps) begin tick = 1; pcnt_n = 0; end
         else pcnt_n = m_pcnt + 16'd1;
      end
      if (tick) begin
         hit   = (m_cnt == m_cmp);
         cnt_n = (hit && m_ctrl[1]) ? 32'd0 : m_cnt + 32'd1;
      end
      if (we && a < 32'd256) m_ram[a[7:2]] = d;
      if (we && (a & ~32'h1F) == TB) begin
         case (a[4:2])
            3'd0: m_ctrl = d & M_CTRL_MASK;
            3'd1: begin m_ps = d[15:0]; pcnt_n = 0; end
            3'd2: cnt_n = d;
            3'd3: m_cmp = d;
            3'd4: if (d[0]) match_n = 0;
            default: ;
         endcase
      end
      if (hit) match_n = 1;
      m_pcnt = pcnt_n; m_cnt = cnt_n; m_match = match_n;
      m_irq = m_match & m_ctrl[2];
   endtask

   // one bus cycle: inputs driven just after an edge, model advanced at the next edge
   task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic chk, input logic use_model, input logic [31:0] expv,
                      input string nm);
      memwrite = we; memaddr = a; memwritedata = d; chk_en = chk;
      if (chk) begin
         exp_q.push_back(use_model ? m_read(a) : expv);
         name_q.push_back(nm);
      end
      @(posedge clk);
      m_step(we, a, d);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      cyc(1'b1, a, d, 1'b0, 1'b0, 32'd0, "");
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
      cyc(1'b0, a, 32'd0, 1'b1, 1'b0, e, nm);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, "");
   endtask

   always @(negedge clk) begin
      if (!reset && chk_en) begin
         n_chk++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got read %h with no expected entry", memreaddata);
         end else begin
            logic [31:0] e;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (memreaddata !== e) begin
               n_fail++;
               $display("FAIL %s: addr %h got %h expected %h", nm, memaddr, memreaddata, e);
            end
         end
      end
`ifdef TIMER_IRQ_EN
      if (!reset) begin
         n_chk++;
         if (irq !== m_irq) begin
            n_fail++;
            $display("FAIL irq: got %b expected %b at %0t", irq, m_irq, $time);
         end
      end
`endif
   end

   initial begin
      logic [31:0] a, d;
      int          r;
      m_reset();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      for (int i = 0; i < 64; i++) wr(32'(i * 4), $urandom);

      // dirty the timer, then reset asynchronously mid-cycle
      wr(TB + 32'h04, 32'd2); wr(TB + 32'h08, 32'd123); wr(TB + 32'h0C, 32'd7);
      wr(TB + 32'h00, 32'd3); idle(5);
      #2 reset = 1'b1;
      m_reset();
      memwrite = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < 8; i++) rd(TB + 32'(i * 4), 32'd0, "reset_reg");
      rd(32'h1000_0000, 32'd0, "unmapped_read");

      // RAM path
      cyc(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'd0, "ram_old_in_write_cycle");
      rd(32'h10, 32'hDEAD_BEEF, "ram_after_write");
      wr(32'h110, 32'h1234_5678);
      rd(32'h13, 32'hDEAD_BEEF, "ram_low_bits_unmapped_alias");

      // prescaled count and hold
      wr(TB + 32'h04, 32'd3); wr(TB + 32'h00, 32'd1);
      idle(20);
      rd(TB + 32'h08, 32'd5, "prescale_count");
      wr(TB + 32'h00, 32'd0);
      idle(10);
      rd(TB + 32'h08, 32'd5, "count_hold");

      // match with auto-reload
      wr(TB + 32'h08, 32'd0); wr(TB + 32'h04, 32'd0); wr(TB + 32'h0C, 32'd4);
      wr(TB + 32'h00, 32'd3);
      rd(TB + 32'h08, 32'd0, "ar_seq0"); rd(TB + 32'h08, 32'd1, "ar_seq1");
      rd(TB + 32'h08, 32'd2, "ar_seq2"); rd(TB + 32'h08, 32'd3, "ar_seq3");
      rd(TB + 32'h08, 32'd4, "ar_seq4"); rd(TB + 32'h08, 32'd0, "ar_seq5");
      rd(TB + 32'h08, 32'd1, "ar_seq6");
      rd(TB + 32'h10, 32'd1, "match_set");
      wr(TB + 32'h00, 32'd0);
      wr(TB + 32'h10, 32'd0);
      rd(TB + 32'h10, 32'd1, "w0_status_no_effect");
      wr(TB + 32'h10, 32'd1);
      rd(TB + 32'h10, 32'd0, "w1c_clears");
      wr(TB + 32'h08, 32'd0); wr(TB + 32'h0C, 32'd2); wr(TB + 32'h00, 32'd3);
      idle(2);
      wr(TB + 32'h10, 32'd1);
      rd(TB + 32'h10, 32'd1, "w1c_vs_match_set_wins");
      wr(TB + 32'h00, 32'd0); wr(TB + 32'h10, 32'd1);

      // wrap and write override
      wr(TB + 32'h08, 32'hFFFF_FFFF); wr(TB + 32'h0C, 32'd5); wr(TB + 32'h00, 32'd1);
      rd(TB + 32'h08, 32'hFFFF_FFFF, "wrap_before");
      rd(TB + 32'h08, 32'd0, "wrap_after");
      rd(TB + 32'h10, 32'd0, "wrap_no_match");
      wr(TB + 32'h08, 32'd100);
      rd(TB + 32'h08, 32'd100, "count_write_override");
      wr(TB + 32'h00, 32'd0);

      // CTRL bit2 and irq
      wr(TB + 32'h00, 32'hFFFF_FFFF);
      rd(TB + 32'h00, M_CTRL_MASK, "ctrl_mask");
      wr(TB + 32'h00, 32'd0);
      wr(TB + 32'h08, 32'd0); wr(TB + 32'h0C, 32'd2); wr(TB + 32'h00, 32'd7);
      idle(4);
      wr(TB + 32'h00, 32'd0); wr(TB + 32'h10, 32'd1); idle(2);

      // randomized traffic against the model
      for (int n = 0; n < 2000; n++) begin
         r = $urandom_range(0, 99);
         if (r < 35) a = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
         else if (r < 85) a = TB + 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
         else begin
            case ($urandom_range(0, 2))
               0: a = 32'h100 + 32'($urandom_range(0, 63) * 4);
               1: a = TB + 32'h20 + 32'($urandom_range(0, 7) * 4);
               default: a = 32'h1000_0000 | $urandom;
            endcase
         end
         d = $urandom;
         if ((a & ~32'h1F) == TB) begin
            case (a[4:2])
               3'd1: d = d & 32'hFFFF_0003;
               3'd2: d = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 10));
               3'd3: d = 32'($urandom_range(0, 10));
               default: ;
            endcase
         end
         cyc(($urandom_range(0, 2) == 0), a, d, 1'b1, 1'b1, 32'd0, "random");
      end

      chk_en = 1'b0;
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
